// File: rtl/timer_irq_dev_pkg.sv
// Register map, CTRL field positions, mode and FSM state encodings for timer_irq_dev.
package timer_irq_dev_pkg;

  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_PRESET = 2'd1;
  localparam logic [1:0] OFS_COUNT  = 2'd2;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'd0,
    MODE_RELOAD  = 2'd1,
    MODE_RSVD2   = 2'd2,
    MODE_RSVD3   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_irq_dev.sv
// Memory-mapped countdown timer with maskable interrupt output (CTRL/PRESET/COUNT).
module timer_irq_dev
  import timer_irq_dev_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_flag;
  state_t      r_state;

  state_t      w_state_nxt;
  logic [31:0] w_count_nxt;
  logic        w_flag_set;
  logic        w_flag_clr;
  logic        w_en_clr;
  logic        w_ctrl_wr;
  logic        w_preset_wr;
  logic        w_en;
  mode_t       w_mode;

  assign w_ctrl_wr   = we && (addr == OFS_CTRL);
  assign w_preset_wr = we && (addr == OFS_PRESET);
  assign w_en        = r_ctrl[CTRL_EN];
  assign w_mode      = mode_t'(r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO]);
  assign irq         = r_flag & r_ctrl[CTRL_IM];

  // FSM next-state, count and flag/EN side effects
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_flag_set  = 1'b0;
    w_flag_clr  = 1'b0;
    w_en_clr    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_en) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!w_en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_count > 32'd1) begin
          w_count_nxt = r_count - 32'd1;
        end else begin
          w_count_nxt = '0;
          w_flag_set  = 1'b1;
          w_state_nxt = ST_INT;
        end
      end
      ST_INT: begin
        w_state_nxt = ST_IDLE;
        if (w_mode == MODE_RELOAD) w_flag_clr = 1'b1;
        else                       w_en_clr   = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, COUNT and interrupt flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      // CTRL writes acknowledge the interrupt, ahead of any FSM set/clear
      if (w_ctrl_wr)       r_flag <= 1'b0;
      else if (w_flag_set) r_flag <= 1'b1;
      else if (w_flag_clr) r_flag <= 1'b0;
    end
  end

  // Bus writes to CTRL/PRESET; a CTRL write beats the one-shot EN clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl   <= '0;
      r_preset <= '0;
    end else begin
      if (w_ctrl_wr)     r_ctrl           <= wdata[3:0];
      else if (w_en_clr) r_ctrl[CTRL_EN]  <= 1'b0;
      if (w_preset_wr)   r_preset         <= wdata;
    end
  end

  // Combinational read mux
  always_comb begin
    rdata = '0;
    case (addr)
      OFS_CTRL:   rdata = {28'd0, r_ctrl};
      OFS_PRESET: rdata = r_preset;
      OFS_COUNT:  rdata = r_count;
      default:    rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_irq_dev.sv
// Scoreboard bench for timer_irq_dev: directed bus steps push expectations, a negedge monitor compares.
module tb_timer_irq_dev;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic        chk_valid;

  typedef struct {
    string       nm;
    logic [31:0] rd;
    bit          crd;
    logic        irq;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp;
  int   n_bad;

  timer_irq_dev dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: mid-cycle, pop one expectation per flagged cycle and compare
  always @(negedge clk) begin
    if (chk_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL underflow: no expectation queued at %0t", $time);
      end else begin
        e = q.pop_front();
        if (e.crd) begin
          n_cmp++;
          if (rdata !== e.rd) begin
            n_bad++;
            $display("FAIL %s rdata: got %h want %h", e.nm, rdata, e.rd);
          end
        end
        n_cmp++;
        if (irq !== e.irq) begin
          n_bad++;
          $display("FAIL %s irq: got %b want %b", e.nm, irq, e.irq);
        end
      end
    end
  end

  // One bus cycle: drive, optionally queue an expectation for this cycle, advance past the edge
  task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d,
                      input bit chk, input string nm, input logic [31:0] erd,
                      input bit crd, input logic eirq);
    exp_t x;
    we    = w;
    addr  = a;
    wdata = d;
    if (chk) begin
      x.nm  = nm;
      x.rd  = erd;
      x.crd = crd;
      x.irq = eirq;
      q.push_back(x);
    end
    chk_valid = chk;
    @(posedge clk);
    #1;
    we        = 1'b0;
    chk_valid = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1'b1, a, d, 1'b0, "", '0, 1'b0, 1'b0);
  endtask

  task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] erd, input logic eirq);
    step(1'b0, a, '0, 1'b1, nm, erd, 1'b1, eirq);
  endtask

  task automatic irqchk(input string nm, input logic eirq);
    step(1'b0, 2'd3, '0, 1'b1, nm, '0, 1'b0, eirq);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    we = 1'b0;
    addr = '0;
    wdata = '0;
    chk_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state and register access
    rd("rst_ctrl",   2'd0, 32'd0, 1'b0);
    rd("rst_preset", 2'd1, 32'd0, 1'b0);
    rd("rst_count",  2'd2, 32'd0, 1'b0);
    rd("rst_ofs3",   2'd3, 32'd0, 1'b0);
    wr(2'd2, 32'd5);
    rd("count_ro", 2'd2, 32'd0, 1'b0);
    wr(2'd1, 32'hDEAD_BEEF);
    rd("preset_rw", 2'd1, 32'hDEAD_BEEF, 1'b0);
    wr(2'd0, 32'hFFFF_FFF6);
    rd("ctrl_trunc", 2'd0, 32'h6, 1'b0);
    wr(2'd0, 32'h0);

    // one-shot, PRESET=3
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    rd("os_c0", 2'd2, 32'd0, 1'b0);
    rd("os_c1", 2'd2, 32'd0, 1'b0);
    rd("os_c2", 2'd2, 32'd3, 1'b0);
    rd("os_c3", 2'd2, 32'd2, 1'b0);
    rd("os_c4", 2'd2, 32'd1, 1'b0);
    rd("os_c5", 2'd2, 32'd0, 1'b1);
    rd("os_ctrl", 2'd0, 32'h8, 1'b1);
    for (int i = 0; i < 100; i++) irqchk("os_hold", 1'b1);
    wr(2'd0, 32'h8);
    rd("os_ack", 2'd0, 32'h8, 1'b0);

    // auto-reload, PRESET=2: pulse at c4, c9, c14, c19
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    for (int i = 0; i < 24; i++)
      rd("ar_cycle", 2'd0, 32'hB, (i >= 4) && (((i - 4) % 5) == 0));
    wr(2'd0, 32'h0);
    irqchk("ar_stop", 1'b0);

    // masked: IM=0 never raises irq
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int i = 0; i < 10; i++) irqchk("mask", 1'b0);

    // pause at 7 with PRESET=10, then re-enable reloads
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    rd("pz_c0", 2'd2, 32'd0, 1'b0);
    rd("pz_c1", 2'd2, 32'd0, 1'b0);
    rd("pz_c2", 2'd2, 32'd10, 1'b0);
    rd("pz_c3", 2'd2, 32'd9, 1'b0);
    wr(2'd0, 32'h0);
    for (int i = 0; i < 20; i++) rd("pz_hold", 2'd2, 32'd7, 1'b0);
    wr(2'd0, 32'h9);
    rd("re_c0", 2'd2, 32'd7, 1'b0);
    rd("re_c1", 2'd2, 32'd7, 1'b0);
    rd("re_c2", 2'd2, 32'd10, 1'b0);
    rd("re_c3", 2'd2, 32'd9, 1'b0);

    // asynchronous reset mid-count
    reset = 1'b1;
    rd("rst_mid_count", 2'd2, 32'd0, 1'b0);
    rd("rst_mid_ctrl",  2'd0, 32'd0, 1'b0);
    reset = 1'b0;

    // PRESET=0 behaves like PRESET=1
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    irqchk("p0_c0", 1'b0);
    irqchk("p0_c1", 1'b0);
    rd("p0_c2", 2'd2, 32'd0, 1'b0);
    rd("p0_c3", 2'd2, 32'd0, 1'b1);
    wr(2'd0, 32'h0);

    // PRESET=1, then a CTRL=0x9 write in the INT cycle restarts the timer
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    irqchk("p1_c0", 1'b0);
    irqchk("p1_c1", 1'b0);
    rd("p1_c2", 2'd2, 32'd1, 1'b0);
    step(1'b1, 2'd0, 32'h9, 1'b1, "ov_int", 32'h9, 1'b1, 1'b1);
    rd("ov_c4", 2'd0, 32'h9, 1'b0);
    rd("ov_c5", 2'd0, 32'h9, 1'b0);
    rd("ov_c6", 2'd2, 32'd1, 1'b0);
    rd("ov_c7", 2'd2, 32'd0, 1'b1);
    rd("ov_c8", 2'd0, 32'h8, 1'b1);

    repeat (2) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
